// File: rtl/ntt_agu_pkg.sv
// Shared types and helpers for the NTT address generator.
package ntt_agu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_SCALE = 2'd2,
      ST_DRAIN = 2'd3
   } agu_state_e;

   localparam logic MODE_FWD = 1'b0;
   localparam logic MODE_INV = 1'b1;

   // Number of butterfly layers for an n-point transform.
   function automatic int unsigned ntt_layers(input int unsigned n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/ntt_agu_dly.sv
// Fixed-latency write-back delay line: DEPTH stages of {valid, a, b}.
module ntt_agu_dly #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 8
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          in_valid_i,
   input  logic [AW-1:0] in_a_i,
   input  logic [AW-1:0] in_b_i,
   output logic          out_valid_o,
   output logic [AW-1:0] out_a_o,
   output logic [AW-1:0] out_b_o
);

   logic [DEPTH-1:0]         vld_q, vld_d;
   logic [DEPTH-1:0][AW-1:0] a_q, a_d;
   logic [DEPTH-1:0][AW-1:0] b_q, b_d;

   // Shift every cycle; stage 0 takes the new entry.
   always_comb begin
      vld_d[0] = in_valid_i;
      a_d[0]   = in_a_i;
      b_d[0]   = in_b_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
         vld_d[i] = vld_q[i-1];
         a_d[i]   = a_q[i-1];
         b_d[i]   = b_q[i-1];
      end
   end

   // Stage registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vld_q <= '0;
         a_q   <= '0;
         b_q   <= '0;
      end else begin
         vld_q <= vld_d;
         a_q   <= a_d;
         b_q   <= b_d;
      end
   end

   assign out_valid_o = vld_q[DEPTH-1];
   assign out_a_o     = a_q[DEPTH-1];
   assign out_b_o     = b_q[DEPTH-1];

endmodule

// File: rtl/ntt_agu_pipe.sv
// NTT butterfly address generator with issue handshake and write-back delay line.
module ntt_agu_pipe
   import ntt_agu_pkg::*;
#(
   parameter int unsigned N      = 256,
   parameter int unsigned AW     = $clog2(N),
   parameter int unsigned BF_LAT = 4,
   parameter int unsigned LW     = $clog2($clog2(N) + 1)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          start_i,
   input  logic          inv_i,
   output logic          busy_o,
   output logic          done_o,
   output logic          rd_valid_o,
   input  logic          rd_ready_i,
   output logic [AW-1:0] rd_addr_a_o,
   output logic [AW-1:0] rd_addr_b_o,
   output logic [AW-1:0] zeta_idx_o,
   output logic          zeta_neg_o,
   output logic          scale_o,
   output logic [LW-1:0] layer_o,
   output logic          wr_en_o,
   output logic [AW-1:0] wr_addr_a_o,
   output logic [AW-1:0] wr_addr_b_o
);

   localparam int unsigned XW     = AW + 1;
   localparam int unsigned CW     = $clog2(BF_LAT + 1);
   localparam int unsigned LAYERS = ntt_layers(N);
   localparam logic [XW-1:0] N_X    = XW'(N);
   localparam logic [XW-1:0] HALF_X = XW'(N / 2);
   localparam logic [XW-1:0] ONE_X  = XW'(1);

   agu_state_e    state_q, state_d;
   logic          inv_q, inv_d;
   logic [XW-1:0] len_q, len_d;
   logic [XW-1:0] start_q, start_d;
   logic [XW-1:0] j_q, j_d;
   logic [AW-1:0] b_q, b_d;
   logic [AW-1:0] zeta_q, zeta_d;
   logic [LW-1:0] layer_q, layer_d;
   logic          valid_q, valid_d;
   logic          neg_q, neg_d;
   logic          scale_q, scale_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic          accept;
   logic          last_layer;
   logic          go_drain;
   logic [XW-1:0] j_inc;
   logic [XW-1:0] grp_end;
   logic [XW-1:0] nxt_start;
   logic [AW-1:0] zeta_step;

   assign accept     = valid_q & rd_ready_i;
   assign j_inc      = j_q + ONE_X;
   assign grp_end    = start_q + len_q;
   assign nxt_start  = start_q + (len_q << 1);
   assign zeta_step  = (inv_q == MODE_INV) ? (zeta_q - AW'(1)) : (zeta_q + AW'(1));
   assign last_layer = (inv_q == MODE_FWD) ? (len_q == ONE_X) : (len_q == HALF_X);

   // Schedule sequencing: next-state and next-output computation.
   always_comb begin
      state_d  = state_q;
      inv_d    = inv_q;
      len_d    = len_q;
      start_d  = start_q;
      j_d      = j_q;
      zeta_d   = zeta_q;
      layer_d  = layer_q;
      valid_d  = valid_q;
      neg_d    = neg_q;
      scale_d  = scale_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      cnt_d    = cnt_q;
      go_drain = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d = ST_RUN;
               inv_d   = inv_i;
               len_d   = inv_i ? ONE_X : HALF_X;
               start_d = '0;
               j_d     = '0;
               zeta_d  = inv_i ? AW'(N - 1) : AW'(1);
               layer_d = '0;
               valid_d = 1'b1;
               neg_d   = inv_i;
               scale_d = 1'b0;
               busy_d  = 1'b1;
            end
         end
         ST_RUN: begin
            if (accept) begin
               if (j_inc < grp_end) begin
                  j_d = j_inc;
               end else if (nxt_start < N_X) begin
                  start_d = nxt_start;
                  j_d     = nxt_start;
                  zeta_d  = zeta_step;
               end else if (!last_layer) begin
                  len_d   = (inv_q == MODE_INV) ? (len_q << 1) : (len_q >> 1);
                  start_d = '0;
                  j_d     = '0;
                  zeta_d  = zeta_step;
                  layer_d = layer_q + LW'(1);
               end else if (inv_q == MODE_INV) begin
                  state_d = ST_SCALE;
                  len_d   = HALF_X;
                  start_d = '0;
                  j_d     = '0;
                  zeta_d  = '0;
                  neg_d   = 1'b0;
                  scale_d = 1'b1;
                  layer_d = LW'(LAYERS);
               end else begin
                  go_drain = 1'b1;
               end
            end
         end
         ST_SCALE: begin
            if (accept) begin
               if (j_inc < HALF_X) begin
                  j_d = j_inc;
               end else begin
                  go_drain = 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            // Counter tracks when the final accepted pair exits the delay line.
            done_d = (cnt_q == CW'(1));
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Final pair accepted: park the read side and wait for write-back.
      if (go_drain) begin
         state_d = ST_DRAIN;
         valid_d = 1'b0;
         len_d   = '0;
         start_d = '0;
         j_d     = '0;
         zeta_d  = '0;
         layer_d = '0;
         neg_d   = 1'b0;
         scale_d = 1'b0;
         cnt_d   = CW'(BF_LAT - 1);
         done_d  = (BF_LAT == 1);
      end

      b_d = AW'(j_d + len_d);
   end

   // State and output registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         inv_q   <= 1'b0;
         len_q   <= '0;
         start_q <= '0;
         j_q     <= '0;
         b_q     <= '0;
         zeta_q  <= '0;
         layer_q <= '0;
         valid_q <= 1'b0;
         neg_q   <= 1'b0;
         scale_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         inv_q   <= inv_d;
         len_q   <= len_d;
         start_q <= start_d;
         j_q     <= j_d;
         b_q     <= b_d;
         zeta_q  <= zeta_d;
         layer_q <= layer_d;
         valid_q <= valid_d;
         neg_q   <= neg_d;
         scale_q <= scale_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign rd_valid_o  = valid_q;
   assign rd_addr_a_o = j_q[AW-1:0];
   assign rd_addr_b_o = b_q;
   assign zeta_idx_o  = zeta_q;
   assign zeta_neg_o  = neg_q;
   assign scale_o     = scale_q;
   assign layer_o     = layer_q;

   ntt_agu_dly #(
      .DEPTH (BF_LAT),
      .AW    (AW)
   ) u_dly (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .in_valid_i  (accept),
      .in_a_i      (accept ? j_q[AW-1:0] : '0),
      .in_b_i      (accept ? b_q : '0),
      .out_valid_o (wr_en_o),
      .out_a_o     (wr_addr_a_o),
      .out_b_o     (wr_addr_b_o)
   );

endmodule

// File: tb/tb_ntt_agu_pipe.sv
// Directed bench for ntt_agu_pipe: three sizes, forward/inverse, stalls, reset abort.
module tb_ntt_agu_pipe;

   typedef struct {
      int a;
      int b;
      int z;
      int neg;
      int scale;
      int layer;
   } pair_t;

   typedef struct {
      int cyc;
      int a;
      int b;
   } wr_t;

   logic       clk_i     = 1'b0;
   logic       rst_ni    = 1'b0;
   logic       drv_start = 1'b0;
   logic       drv_inv   = 1'b0;
   logic       drv_ready = 1'b0;
   logic [1:0] sel       = 2'd0;
   int         cyc       = 0;
   int         n_checks  = 0;
   int         n_fail    = 0;

   pair_t exp_q[$];
   wr_t   wq[$];

   always #5 clk_i = ~clk_i;

   // Cycle counter for latency checks.
   always @(posedge clk_i) cyc <= cyc + 1;

   logic       s8_busy, s8_done, s8_valid, s8_neg, s8_scale, s8_wr;
   logic [2:0] s8_a, s8_b, s8_z, s8_wa, s8_wb;
   logic [1:0] s8_layer;
   logic       s16_busy, s16_done, s16_valid, s16_neg, s16_scale, s16_wr;
   logic [3:0] s16_a, s16_b, s16_z, s16_wa, s16_wb;
   logic [2:0] s16_layer;
   logic       s256_busy, s256_done, s256_valid, s256_neg, s256_scale, s256_wr;
   logic [7:0] s256_a, s256_b, s256_z, s256_wa, s256_wb;
   logic [3:0] s256_layer;

   ntt_agu_pipe #(.N(8), .BF_LAT(4)) u_agu8 (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(drv_start && (sel == 2'd0)), .inv_i(drv_inv),
      .busy_o(s8_busy), .done_o(s8_done), .rd_valid_o(s8_valid), .rd_ready_i(drv_ready),
      .rd_addr_a_o(s8_a), .rd_addr_b_o(s8_b), .zeta_idx_o(s8_z), .zeta_neg_o(s8_neg),
      .scale_o(s8_scale), .layer_o(s8_layer), .wr_en_o(s8_wr), .wr_addr_a_o(s8_wa),
      .wr_addr_b_o(s8_wb));

   ntt_agu_pipe #(.N(16), .BF_LAT(1)) u_agu16 (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(drv_start && (sel == 2'd1)), .inv_i(drv_inv),
      .busy_o(s16_busy), .done_o(s16_done), .rd_valid_o(s16_valid), .rd_ready_i(drv_ready),
      .rd_addr_a_o(s16_a), .rd_addr_b_o(s16_b), .zeta_idx_o(s16_z), .zeta_neg_o(s16_neg),
      .scale_o(s16_scale), .layer_o(s16_layer), .wr_en_o(s16_wr), .wr_addr_a_o(s16_wa),
      .wr_addr_b_o(s16_wb));

   ntt_agu_pipe #(.N(256), .BF_LAT(4)) u_agu256 (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(drv_start && (sel == 2'd2)), .inv_i(drv_inv),
      .busy_o(s256_busy), .done_o(s256_done), .rd_valid_o(s256_valid), .rd_ready_i(drv_ready),
      .rd_addr_a_o(s256_a), .rd_addr_b_o(s256_b), .zeta_idx_o(s256_z), .zeta_neg_o(s256_neg),
      .scale_o(s256_scale), .layer_o(s256_layer), .wr_en_o(s256_wr), .wr_addr_a_o(s256_wa),
      .wr_addr_b_o(s256_wb));

   logic [31:0] o_busy, o_done, o_valid, o_a, o_b, o_z, o_neg, o_scale, o_layer;
   logic [31:0] o_wr, o_wa, o_wb, o_pack, o_any;

   // Route the selected instance onto common 32-bit observation signals.
   always_comb begin
      case (sel)
         2'd0: begin
            o_busy = 32'(s8_busy);  o_done = 32'(s8_done);   o_valid = 32'(s8_valid);
            o_a = 32'(s8_a);        o_b = 32'(s8_b);         o_z = 32'(s8_z);
            o_neg = 32'(s8_neg);    o_scale = 32'(s8_scale); o_layer = 32'(s8_layer);
            o_wr = 32'(s8_wr);      o_wa = 32'(s8_wa);       o_wb = 32'(s8_wb);
         end
         2'd1: begin
            o_busy = 32'(s16_busy); o_done = 32'(s16_done);   o_valid = 32'(s16_valid);
            o_a = 32'(s16_a);       o_b = 32'(s16_b);         o_z = 32'(s16_z);
            o_neg = 32'(s16_neg);   o_scale = 32'(s16_scale); o_layer = 32'(s16_layer);
            o_wr = 32'(s16_wr);     o_wa = 32'(s16_wa);       o_wb = 32'(s16_wb);
         end
         default: begin
            o_busy = 32'(s256_busy); o_done = 32'(s256_done);   o_valid = 32'(s256_valid);
            o_a = 32'(s256_a);       o_b = 32'(s256_b);         o_z = 32'(s256_z);
            o_neg = 32'(s256_neg);   o_scale = 32'(s256_scale); o_layer = 32'(s256_layer);
            o_wr = 32'(s256_wr);     o_wa = 32'(s256_wa);       o_wb = 32'(s256_wb);
         end
      endcase
      o_pack = {o_a[7:0], o_b[7:0], o_z[7:0], o_layer[3:0], o_neg[0], o_scale[0], o_valid[0], 1'b0};
      o_any  = o_busy | o_done | o_valid | o_a | o_b | o_z | o_neg | o_scale | o_layer |
               o_wr | o_wa | o_wb;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference schedule written directly from the butterfly loop nest.
   function automatic void build_exp(input int n, input bit inv);
      pair_t p;
      int    lg;
      int    z;
      int    len;
      lg = $clog2(n);
      z  = inv ? n - 1 : 1;
      exp_q.delete();
      for (int l = 0; l < lg; l++) begin
         len = inv ? (1 << l) : (n >> (l + 1));
         for (int s = 0; s < n; s += 2 * len) begin
            for (int j = s; j < s + len; j++) begin
               p.a = j; p.b = j + len; p.z = z; p.neg = int'(inv); p.scale = 0; p.layer = l;
               exp_q.push_back(p);
            end
            z = inv ? z - 1 : z + 1;
         end
      end
      if (inv) begin
         for (int j = 0; j < n / 2; j++) begin
            p.a = j; p.b = j + n / 2; p.z = 0; p.neg = 0; p.scale = 1; p.layer = lg;
            exp_q.push_back(p);
         end
      end
   endfunction

   // One transform: start, drive ready, check every issue and write-back, then idle.
   task automatic run(input int n, input bit inv, input int pct, input int stall_at,
                      input int mid_start_at, input int abort_at);
      int    bf, lg, n_acc, count_exp, first_acc, last_acc, stall_left, budget;
      bit    done_seen, prev_stall, rdy, first;
      logic [31:0] prev_pack;
      pair_t e;
      wr_t   w;
      int    wcnt[256];

      sel        = (n == 8) ? 2'd0 : ((n == 16) ? 2'd1 : 2'd2);
      bf         = (n == 16) ? 1 : 4;
      lg         = $clog2(n);
      build_exp(n, inv);
      wq.delete();
      for (int i = 0; i < 256; i++) wcnt[i] = 0;
      count_exp  = exp_q.size();
      budget     = count_exp * 8 + 50;
      n_acc      = 0;
      first_acc  = -1;
      last_acc   = 0;
      stall_left = 5;
      done_seen  = 1'b0;
      prev_stall = 1'b0;
      prev_pack  = '0;
      first      = 1'b1;
      drv_inv    = inv;
      drv_ready  = 1'b0;
      drv_start  = 1'b1;

      for (int c = 0; c < budget && !done_seen; c++) begin
         @(negedge clk_i);
         drv_start = 1'b0;
         drv_inv   = inv;
         if (abort_at >= 0 && n_acc == abort_at) begin
            drv_ready = 1'b0;
            rst_ni    = 1'b0;
            #1;
            check_eq("rst_async_outputs", o_any, 32'd0);
            @(negedge clk_i);
            rst_ni = 1'b1;
            repeat (6) begin
               @(negedge clk_i);
               check_eq("post_rst_wr_en", o_wr, 32'd0);
               check_eq("post_rst_done", o_done, 32'd0);
               check_eq("post_rst_busy", o_busy, 32'd0);
            end
            return;
         end
         if (first) begin
            check_eq("busy_after_start", o_busy, 32'd1);
            first = 1'b0;
         end
         if (o_wr[0]) begin
            if (wq.size() == 0) check_eq("wr_without_accept", 32'd1, 32'd0);
            else begin
               w = wq.pop_front();
               check_eq("wr_latency", cyc - w.cyc, bf);
               check_eq("wr_addr_a", o_wa, w.a);
               check_eq("wr_addr_b", o_wb, w.b);
            end
            if (o_wa < 32'd256) wcnt[o_wa]++;
            if (o_wb < 32'd256) wcnt[o_wb]++;
         end
         if (o_done[0]) begin
            check_eq("done_with_wr_en", o_wr, 32'd1);
            check_eq("done_all_issued", exp_q.size(), 32'd0);
            check_eq("done_nothing_inflight", wq.size(), 32'd0);
            check_eq("done_latency", cyc - last_acc, bf);
            if (pct == 100 && stall_at < 0)
               check_eq("issue_no_bubble", last_acc - first_acc, count_exp - 1);
            done_seen = 1'b1;
         end else begin
            check_eq("rd_valid", o_valid, 32'(exp_q.size() > 0));
            if (prev_stall) check_eq("stall_hold", o_pack, prev_pack);
            rdy = ($urandom_range(99, 0) < pct);
            if (stall_at >= 0 && n_acc == stall_at && stall_left > 0) begin
               rdy = 1'b0;
               stall_left--;
            end
            if (mid_start_at >= 0 && n_acc == mid_start_at) begin
               drv_start = 1'b1;
               drv_inv   = !inv;
            end
            if (o_valid[0] && rdy) begin
               if (exp_q.size() == 0) check_eq("accept_beyond_end", 32'd1, 32'd0);
               else begin
                  e = exp_q.pop_front();
                  check_eq("rd_addr_a", o_a, e.a);
                  check_eq("rd_addr_b", o_b, e.b);
                  check_eq("zeta_idx", o_z, e.z);
                  check_eq("zeta_neg", o_neg, e.neg);
                  check_eq("scale", o_scale, e.scale);
                  check_eq("layer", o_layer, e.layer);
               end
               w.cyc = cyc; w.a = int'(o_a); w.b = int'(o_b);
               wq.push_back(w);
               if (first_acc < 0) first_acc = cyc;
               last_acc = cyc;
               n_acc++;
            end
            prev_stall = o_valid[0] && !rdy;
            prev_pack  = o_pack;
            drv_ready  = rdy;
         end
      end

      if (!done_seen) check_eq("timeout_waiting_done", 32'd0, 32'd1);
      else begin
         @(negedge clk_i);
         check_eq("busy_falls_after_done", o_busy, 32'd0);
         check_eq("rd_valid_idle", o_valid, 32'd0);
         check_eq("accept_count", n_acc, count_exp);
         for (int i = 0; i < n; i++)
            check_eq("writes_per_address", wcnt[i], inv ? lg + 1 : lg);
      end
   endtask

   initial begin
      rst_ni = 1'b0;
      repeat (3) @(negedge clk_i);
      for (int s = 0; s < 3; s++) begin
         sel = 2'(s);
         #1;
         check_eq("reset_outputs", o_any, 32'd0);
      end
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);

      run(8,   1'b0, 100, -1,  5,  -1);
      run(8,   1'b1, 100, -1, -1,  -1);
      run(256, 1'b0, 50,  -1, -1,  -1);
      run(256, 1'b0, 100, -1, -1, 320);
      run(256, 1'b0, 100, -1, -1,  -1);
      run(16,  1'b0, 100, 12, -1,  -1);
      run(16,  1'b1, 50,  -1, -1,  -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ntt_agu_pipe.md
Name: ntt_agu_pipe

Overview:
Parametrised successor of the NTT address generator. It sequences both forward (Cooley-Tukey) and inverse (Gentleman-Sande) NTT butterfly schedules over an N-point polynomial and drives the read address pair and twiddle index for each butterfly. A valid/ready issue handshake lets the memory or butterfly side stall issue. A fixed-latency delay line regenerates the write-back address pair. In inverse mode a final scaling pass follows the layers. It sits between the top-level controller and the coefficient RAM / butterfly unit.

Parameters:
N, 256, transform length; power of two, N >= 8
AW, $clog2(N), coefficient address and twiddle index width
BF_LAT, 4, butterfly latency in cycles from read issue to write-back; >= 1
LW, $clog2($clog2(N)+1), width of layer counter

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  start pulse; sampled only in IDLE
inv_i  in  1  mode at start: 0 forward, 1 inverse; latched on start
busy_o  out  1  high from accepted start until the cycle after done_o
done_o  out  1  one-cycle pulse with the final wr_en_o
rd_valid_o  out  1  an address pair is offered
rd_ready_i  in  1  consumer accepts the pair this cycle
rd_addr_a_o  out  AW  butterfly upper address j
rd_addr_b_o  out  AW  butterfly lower address j+len
zeta_idx_o  out  AW  twiddle ROM index
zeta_neg_o  out  1  1 in inverse layers (use -zeta)
scale_o  out  1  1 during inverse scaling pass
layer_o  out  LW  current layer, 0-based
wr_en_o  out  1  write-back strobe
wr_addr_a_o  out  AW  write address a
wr_addr_b_o  out  AW  write address b

Behaviour:
- Reset: all outputs 0; state IDLE; delay line cleared. Reset mid-operation aborts immediately. No done_o is issued, and nothing resumes after reset release.
- States: IDLE -> RUN on start_i. RUN -> SCALE after the last layer pair is accepted when inv is latched; otherwise RUN -> DRAIN. SCALE -> DRAIN after its last accepted pair. DRAIN -> IDLE when the delay line empties.
- start_i during busy_o is ignored.
- Counters advance only on accept (rd_valid_o && rd_ready_i). While not accepted, rd_valid_o and all rd_*/zeta/flag outputs hold stable.
- rd_valid_o is high in every RUN/SCALE cycle. There is no bubble between groups or layers.
- Forward schedule:
  - len = N/2 down to 1, halving each layer.
  - Groups start at 0, then start = start + 2*len, while start < N.
  - Within a group, j = start .. start+len-1.
  - zeta_idx_o begins at 1 and increments per group, reaching N-1.
  - zeta_neg_o = 0.
- Inverse schedule:
  - len = 1 up to N/2, doubling each layer; same group and j iteration as forward.
  - zeta_idx_o begins at N-1 and decrements per group, reaching 1.
  - zeta_neg_o = 1.
- Scaling pass (inverse only): N/2 pairs (j, j+N/2) for j = 0..N/2-1. zeta_idx_o = 0, scale_o = 1, zeta_neg_o = 0, layer_o = log2(N).
- Pair counts:
  - Forward: (N/2)*log2(N).
  - Inverse: that count plus N/2.
  - For N=256: 1024 forward and 1152 inverse.
- layer_o increments at each len change.
- Arithmetic: len, start and j use AW+1 bits internally so the comparison start+2*len < N is exact with no wrap. Outputs are truncated to AW.
- Delay line: BF_LAT stages of {valid, a, b}, shifting every cycle unconditionally. Stage 0 loads the accepted pair, or valid=0 when there is no accept. wr_en_o/wr_addr_* come from the last stage. A write lands exactly BF_LAT cycles after its accept.
- done_o coincides with wr_en_o of the final pair. busy_o falls the next cycle. A new start_i is accepted the cycle after busy_o falls.

Decomposition:
- Package ntt_agu_pkg holds:
  - state enum (IDLE, RUN, SCALE, DRAIN);
  - mode constants FWD/INV;
  - function clog2-based LAYERS(N).
- Sub-module ntt_agu_dly (parameters DEPTH, AW) is the write-back delay line, reusable for other fixed-latency units.

Test Plan:
- N=8, forward, rd_ready_i=1: pairs (0,4)(1,5)(2,6)(3,7) idx1; (0,2)(1,3) idx2; (4,6)(5,7) idx3; (0,1) idx4, (2,3) idx5, (4,5) idx6, (6,7) idx7. 12 pairs over 12 consecutive cycles. done_o at last accept + BF_LAT.
- N=8, inverse: (0,1) idx7, (2,3) idx6, (4,5) idx5, (6,7) idx4; (0,2)(1,3) idx3; (4,6)(5,7) idx2; (0,4)..(3,7) idx1; then scale (0,4)..(3,7) idx0, scale_o=1. 16 pairs, zeta_neg_o=1 except during scale.
- N=256, forward, random rd_ready_i at 50%: exactly 1024 accepts. Outputs stable while stalled. Each wr_en_o lands BF_LAT cycles after its accept with matching addresses. Every address is written exactly log2N=8 times.
- start_i pulsed mid-run: no effect. start_i in the cycle after busy_o falls: new run begins.
- rst_ni low for 1 cycle mid-layer 3: all outputs 0 asynchronously, no done_o, IDLE after release. A subsequent start_i gives the full sequence from pair (0,128).
- BF_LAT=1, N=16, rd_ready_i held 0 for 5 cycles at a group boundary: rd outputs frozen, no wr_en_o beyond in-flight pairs, sequence resumes without skip or duplicate.
